// File: rtl/ok_trigger_burst_decoder_if.sv
// Host word stream in, endpoint registers and write strobes out.
interface ok_trigger_burst_decoder_if #(
    parameter int unsigned NUM_EP = 8
);
    logic                     data_valid;
    logic [15:0]              ok1;
    logic [NUM_EP*16-1:0]     ep_data;
    logic [NUM_EP-1:0]        ep_update;

    modport master (
        output data_valid, ok1,
        input  ep_data, ep_update
    );

    modport slave (
        input  data_valid, ok1,
        output ep_data, ep_update
    );
endinterface

// File: rtl/ok_trigger_burst_decoder.sv
// Header-framed burst decoder: header, addr/len word, then payload words
// written to consecutive wire (held) or trigger (one-cycle) endpoints.
module ok_trigger_burst_decoder #(
    parameter int unsigned        NUM_EP    = 8,
    parameter logic [7:0]         BASE_ADDR = 8'h40,
    parameter logic [15:0]        HEADER    = 16'hE5C7,
    parameter logic [NUM_EP-1:0]  TRIG_MASK = '0,
    parameter int unsigned        TIMEOUT   = 1023,
    parameter int unsigned        CNT_W     = 10
) (
    input  logic                          clk_in,
    input  logic                          rst,
    ok_trigger_burst_decoder_if.slave     bus,
    output logic [1:0]                    STATE,
    output logic                          busy,
    output logic                          err,
    output logic [7:0]                    err_cnt
);

    localparam int unsigned PTR_W = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic [7:0]         rem, rem_nxt;
    logic [CNT_W-1:0]   tmo, tmo_nxt;
    logic               wr_en;
    logic               err_nxt;
    logic [8:0]         addr_off;

    // Addresses below BASE_ADDR wrap to >= 257 here, so one compare covers both bounds.
    assign addr_off = {1'b0, bus.ok1[15:8]} - {1'b0, BASE_ADDR};

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            ptr   <= '0;
            rem   <= '0;
            tmo   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            rem   <= rem_nxt;
            tmo   <= tmo_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        rem_nxt   = rem;
        tmo_nxt   = tmo;
        wr_en     = 1'b0;
        err_nxt   = 1'b0;
        if (state == S_IDLE) begin
            tmo_nxt = '0;
            if (bus.data_valid && bus.ok1 == HEADER)
                state_nxt = S_ADDR;
        end else if (bus.data_valid) begin
            tmo_nxt = '0;
            case (state)
                S_ADDR: begin
                    rem_nxt = bus.ok1[7:0];
                    if (bus.ok1[7:0] == 8'd0) begin
                        state_nxt = S_IDLE;
                    end else if (addr_off < 9'(NUM_EP)) begin
                        state_nxt = S_DATA;
                        ptr_nxt   = addr_off[PTR_W-1:0];
                    end else begin
                        state_nxt = S_DROP;
                        err_nxt   = 1'b1;
                    end
                end
                S_DATA: begin
                    wr_en   = 1'b1;
                    ptr_nxt = ptr + 1'b1;
                    rem_nxt = rem - 8'd1;
                    if (rem == 8'd1) begin
                        state_nxt = S_IDLE;
                    end else if (ptr == PTR_W'(NUM_EP - 1)) begin
                        state_nxt = S_DROP;
                        err_nxt   = 1'b1;
                    end
                end
                S_DROP: begin
                    rem_nxt = rem - 8'd1;
                    if (rem == 8'd1)
                        state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end else if (tmo == CNT_W'(TIMEOUT - 1)) begin
            state_nxt = S_IDLE;
            err_nxt   = 1'b1;
            tmo_nxt   = '0;
        end else begin
            tmo_nxt = tmo + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            bus.ep_data   <= '0;
            bus.ep_update <= '0;
            err           <= 1'b0;
            err_cnt       <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_EP; i++) begin
                bus.ep_update[i] <= wr_en && (ptr == PTR_W'(i));
                if (wr_en && (ptr == PTR_W'(i)))
                    bus.ep_data[16*i +: 16] <= bus.ok1;
                else if (TRIG_MASK[i])
                    bus.ep_data[16*i +: 16] <= '0;
            end
            err <= err_nxt;
            if (err_nxt && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end

    assign STATE = state;
    assign busy  = (state != S_IDLE);

endmodule
